// File: rtl/axis_processor_pkg.sv
// Shared types and widths for the integrate-and-fire stream processor.
// Optional feature macro: AXIS_PROCESSOR_LEAK_EN (per-beat leak of idle lanes).
package axis_processor_pkg;

   localparam int unsigned DATA_WIDTH        = 32;
   localparam int unsigned KEEP_WIDTH        = 4;
   localparam int unsigned POT_WIDTH_DEFAULT = 8;

   typedef logic [DATA_WIDTH-1:0]        spike_vec_t;
   typedef logic [KEEP_WIDTH-1:0]        keep_vec_t;
   typedef logic [POT_WIDTH_DEFAULT-1:0] pot_t;

   // One buffered AXI-Stream output beat
   typedef struct packed {
      spike_vec_t data;
      keep_vec_t  keep;
      logic       last;
   } axis_beat_t;

endpackage

// File: rtl/axis.sv
// Shared AXI-Stream interface carrying 32-bit spike or fire vectors.
interface axis;
   import axis_processor_pkg::*;

   logic       tvalid;
   logic       tready;
   spike_vec_t tdata;
   keep_vec_t  tkeep;
   logic       tlast;

   modport master (output tvalid, tdata, tkeep, tlast, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_network_processor_if_neuron.sv
// Single integrate-and-fire lane: saturating integrate, fire test, reset on
// fire or end of packet. Leak of idle lanes when AXIS_PROCESSOR_LEAK_EN is set.
module if_neuron #(
   parameter int unsigned THRESHOLD = 1,
   parameter int unsigned WEIGHT    = 1,
   parameter int unsigned POT_WIDTH = 8
) (
   input  logic clk,
   input  logic arstn,
   input  logic en_i,
   input  logic spike_i,
   input  logic last_i,
   output logic fire_c_o
);

   localparam int unsigned SUM_W = POT_WIDTH + 1;

   logic [POT_WIDTH-1:0] pot_q, pot_d, upd;
   logic [SUM_W-1:0]     sum;

   // Candidate potential and fire decision for the beat being accepted
   always_comb begin
      sum = {1'b0, pot_q} + SUM_W'(WEIGHT);
      upd = pot_q;
      if (spike_i) begin
         upd = sum[POT_WIDTH] ? '1 : sum[POT_WIDTH-1:0];
      end else begin
`ifdef AXIS_PROCESSOR_LEAK_EN
         upd = (pot_q != '0) ? pot_q - POT_WIDTH'(1) : pot_q;
`else
         upd = pot_q;
`endif
      end
      fire_c_o = (32'(upd) >= 32'(THRESHOLD));
      pot_d    = pot_q;
      if (en_i) begin
         pot_d = (fire_c_o || last_i) ? '0 : upd;
      end
   end

   // Potential register
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) pot_q <= '0;
      else        pot_q <= pot_d;
   end

endmodule

// File: rtl/axis_network_processor.sv
// Streaming integrate-and-fire processor: 32 lanes, one fire vector out per
// spike vector in, single output register with AXIS backpressure.
// Optional feature macro: AXIS_PROCESSOR_LEAK_EN (handled inside if_neuron).
module axis_network_processor
   import axis_processor_pkg::*;
#(
   parameter int unsigned THRESHOLD = 1,
   parameter int unsigned WEIGHT    = 1,
   parameter int unsigned POT_WIDTH = POT_WIDTH_DEFAULT
) (
   input logic clk,
   input logic arstn,
   axis.slave  s_axis,
   axis.master m_axis
);

   logic       m_valid_q, m_valid_d;
   axis_beat_t beat_q, beat_d;
   logic       s_ready_c;
   logic       accept_c;
   spike_vec_t fire_vec;

   assign s_ready_c = !m_valid_q || m_axis.tready;
   assign accept_c  = s_axis.tvalid && s_ready_c;

   // One neuron per spike lane
   for (genvar i = 0; i < int'(DATA_WIDTH); i++) begin : g_lane
      if_neuron #(
         .THRESHOLD (THRESHOLD),
         .WEIGHT    (WEIGHT),
         .POT_WIDTH (POT_WIDTH)
      ) u_neuron (
         .clk      (clk),
         .arstn    (arstn),
         .en_i     (accept_c),
         .spike_i  (s_axis.tdata[i]),
         .last_i   (s_axis.tlast),
         .fire_c_o (fire_vec[i])
      );
   end

   // Output register next state: load on accept, empty on drain
   always_comb begin
      m_valid_d = m_valid_q;
      beat_d    = beat_q;
      if (accept_c) begin
         m_valid_d = 1'b1;
         beat_d    = '{data: fire_vec, keep: s_axis.tkeep, last: s_axis.tlast};
      end else if (m_axis.tready) begin
         m_valid_d = 1'b0;
      end
   end

   // Output register
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         m_valid_q <= 1'b0;
         beat_q    <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         beat_q    <= beat_d;
      end
   end

   assign s_axis.tready = s_ready_c;
   assign m_axis.tvalid = m_valid_q;
   assign m_axis.tdata  = beat_q.data;
   assign m_axis.tkeep  = beat_q.keep;
   assign m_axis.tlast  = beat_q.last;

endmodule

// File: tb/tb_axis_network_processor.sv
// Bench for axis_network_processor: three configurations driven in lockstep
// and checked cycle by cycle against an arithmetic reference model.
module tb_axis_network_processor;
   import axis_processor_pkg::*;

   localparam int ND = 3;

   logic clk = 1'b0;
   logic arstn = 1'b0;
   always #5 clk = ~clk;

   axis s0 (), m0 (), s1 (), m1 (), s2 (), m2 ();

   axis_network_processor #(.THRESHOLD(1),   .WEIGHT(1),   .POT_WIDTH(8)) dut0 (
      .clk(clk), .arstn(arstn), .s_axis(s0.slave), .m_axis(m0.master));
   axis_network_processor #(.THRESHOLD(2),   .WEIGHT(1),   .POT_WIDTH(8)) dut1 (
      .clk(clk), .arstn(arstn), .s_axis(s1.slave), .m_axis(m1.master));
   axis_network_processor #(.THRESHOLD(255), .WEIGHT(100), .POT_WIDTH(8)) dut2 (
      .clk(clk), .arstn(arstn), .s_axis(s2.slave), .m_axis(m2.master));

   int thr  [ND] = '{1, 2, 255};
   int wgt  [ND] = '{1, 1, 100};
   int pmax [ND] = '{255, 255, 255};

   logic        sr [ND];
   logic        ov [ND];
   logic [31:0] od [ND];
   logic [3:0]  ok [ND];
   logic        ol [ND];
   assign sr[0] = s0.tready; assign sr[1] = s1.tready; assign sr[2] = s2.tready;
   assign ov[0] = m0.tvalid; assign ov[1] = m1.tvalid; assign ov[2] = m2.tvalid;
   assign od[0] = m0.tdata;  assign od[1] = m1.tdata;  assign od[2] = m2.tdata;
   assign ok[0] = m0.tkeep;  assign ok[1] = m1.tkeep;  assign ok[2] = m2.tkeep;
   assign ol[0] = m0.tlast;  assign ol[1] = m1.tlast;  assign ol[2] = m2.tlast;

   // Reference state
   int          pot   [ND][32];
   logic        exp_v [ND];
   logic [31:0] exp_d [ND];
   logic [3:0]  exp_k [ND];
   logic        exp_l [ND];

   logic        src_valid = 1'b0;
   logic [31:0] src_data  = '0;
   logic [3:0]  src_keep  = '0;
   logic        src_last  = 1'b0;
   logic        mready    = 1'b1;
   int          bp_cnt    = 0;
   bit          rnd_ready = 1'b0;

   int checks = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic void model_reset();
      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < 32; i++) pot[d][i] = 0;
         exp_v[d] = 1'b0; exp_d[d] = '0; exp_k[d] = '0; exp_l[d] = 1'b0;
      end
   endfunction

   // Fire vector of one accepted beat, updating the reference potentials
   function automatic logic [31:0] model_beat(int d, logic [31:0] data, logic last);
      logic [31:0] f = '0;
      for (int i = 0; i < 32; i++) begin
         int p = pot[d][i];
         if (data[i]) p = (p + wgt[d] > pmax[d]) ? pmax[d] : p + wgt[d];
`ifdef AXIS_PROCESSOR_LEAK_EN
         else if (p > 0) p = p - 1;
`endif
         f[i] = (p >= thr[d]);
         pot[d][i] = (f[i] || last) ? 0 : p;
      end
      return f;
   endfunction

   task automatic drive();
      s0.tvalid = src_valid; s0.tdata = src_data; s0.tkeep = src_keep; s0.tlast = src_last;
      s1.tvalid = src_valid; s1.tdata = src_data; s1.tkeep = src_keep; s1.tlast = src_last;
      s2.tvalid = src_valid; s2.tdata = src_data; s2.tkeep = src_keep; s2.tlast = src_last;
      m0.tready = mready; m1.tready = mready; m2.tready = mready;
   endtask

   // One clock, entered and left at the falling edge
   task automatic cycle();
      logic acc;
      if (bp_cnt > 0) begin
         mready = 1'b0;
         bp_cnt--;
      end else begin
         mready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      drive();
      #1;
      for (int d = 0; d < ND; d++)
         check($sformatf("s_tready[%0d]", d), 32'(sr[d]), 32'(!exp_v[d] || mready));
      acc = src_valid && (!exp_v[0] || mready);
      @(posedge clk);
      for (int d = 0; d < ND; d++) begin
         if (acc) begin
            exp_d[d] = model_beat(d, src_data, src_last);
            exp_k[d] = src_keep;
            exp_l[d] = src_last;
            exp_v[d] = 1'b1;
         end else if (mready) begin
            exp_v[d] = 1'b0;
         end
      end
      if (acc) src_valid = 1'b0;
      #1;
      for (int d = 0; d < ND; d++) begin
         check($sformatf("m_tvalid[%0d]", d), 32'(ov[d]), 32'(exp_v[d]));
         check($sformatf("m_tdata[%0d]",  d), od[d], exp_d[d]);
         check($sformatf("m_tkeep[%0d]",  d), 32'(ok[d]), 32'(exp_k[d]));
         check($sformatf("m_tlast[%0d]",  d), 32'(ol[d]), 32'(exp_l[d]));
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] data, input logic [3:0] keep, input logic last);
      int n = 0;
      src_valid = 1'b1; src_data = data; src_keep = keep; src_last = last;
      while (src_valid && n < 50) begin
         cycle();
         n++;
      end
      if (src_valid) begin
         check("send_timeout", 32'(src_valid), 32'd0);
         src_valid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      src_valid = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic drain();
      int n = 0;
      src_valid = 1'b0;
      while ((exp_v[0] || exp_v[1] || exp_v[2]) && n < 50) begin
         cycle();
         n++;
      end
      check("drain_timeout", 32'(exp_v[0] || exp_v[1] || exp_v[2]), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      for (int d = 0; d < ND; d++) begin
         check($sformatf("%s_tvalid[%0d]", tag, d), 32'(ov[d]), 32'd0);
         check($sformatf("%s_tdata[%0d]",  tag, d), od[d], 32'd0);
         check($sformatf("%s_tkeep[%0d]",  tag, d), 32'(ok[d]), 32'd0);
         check($sformatf("%s_tlast[%0d]",  tag, d), 32'(ol[d]), 32'd0);
         check($sformatf("%s_tready[%0d]", tag, d), 32'(sr[d]), 32'd1);
      end
   endtask

   initial begin
      model_reset();
      src_valid = 1'b0;
      mready = 1'b1;
      drive();
      arstn = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      arstn = 1'b1;

      // Single spike packet; threshold-2 and saturation lanes see the same beats
      send(32'h1, 4'hF, 1'b0);
      send(32'h0, 4'hF, 1'b0);
      send(32'h0, 4'hF, 1'b0);
      send(32'h0, 4'hF, 1'b1);
      idle(1);

      // Accumulation across beats
      send(32'h3, 4'hF, 1'b0);
      send(32'h1, 4'hF, 1'b0);
      send(32'h2, 4'hF, 1'b0);
      send(32'h0, 4'hF, 1'b1);

      // Potentials clear at packet end
      send(32'h1, 4'hF, 1'b1);
      send(32'h1, 4'hF, 1'b1);

      // Saturation: three heavy spikes on one lane, then partial keep
      send(32'h8000_0001, 4'h3, 1'b0);
      send(32'h8000_0001, 4'h1, 1'b0);
      send(32'h8000_0001, 4'h0, 1'b1);

      // Backpressure mid-packet
      send(32'h0000_00F0, 4'hF, 1'b0);
      bp_cnt = 5;
      send(32'h0000_00FF, 4'hC, 1'b0);
      send(32'h0000_0F0F, 4'hF, 1'b0);
      send(32'h0000_00F0, 4'hA, 1'b1);
      drain();

      // Randomized traffic with random sink stalls and source gaps
      rnd_ready = 1'b1;
      for (int b = 0; b < 150; b++) begin
         if ($urandom_range(0, 5) == 0) idle(1);
         send($urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
      end
      send(32'h0, 4'hF, 1'b1);
      rnd_ready = 1'b0;
      drain();

      // Reset asserted mid-packet
      send(32'h1, 4'hF, 1'b0);
      send(32'h1, 4'hF, 1'b0);
      src_valid = 1'b0;
      drive();
      arstn = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("midrst");
      @(posedge clk);
      #1;
      check_reset_outputs("midrst_hold");
      @(negedge clk);
      arstn = 1'b1;
      send(32'h1, 4'hF, 1'b1);
      drain();

      // Leak behaviour on the threshold-2 configuration
      send(32'h1, 4'hF, 1'b0);
      send(32'h0, 4'hF, 1'b0);
      send(32'h1, 4'hF, 1'b1);
      drain();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Global timeout guard
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/axis_network_processor.md
# axis_network_processor

Streaming integrate-and-fire processor between a DMA's MM2S and S2MM AXI-Stream channels. Each 32-bit input beat is one network timestep and carries a spike vector with one input neuron per bit. The block integrates these spikes into 32 membrane potentials, one per lane. For every input beat it emits one 32-bit output beat holding the vector of neurons that fired. Packet boundaries (`tlast`) delimit independent network runs.

## Interface
- `THRESHOLD`, default 1: firing threshold; a neuron fires when its potential is at least this value.
- `WEIGHT`, default 1: amount added to a neuron's potential per input spike.
- `POT_WIDTH`, default 8: potential register width, unsigned.
- `clk`, input, 1: single clock for everything.
- `arstn`, input, 1: reset, asynchronous and active-low.
- `s_axis`, slave modport of interface `axis`: `tvalid`/`tready`/`tdata[31:0]`/`tkeep[3:0]`/`tlast`; input spike vectors.
- `m_axis`, master modport of interface `axis`: same signal set; output fire vectors.

## Operation
- A transfer occurs on any rising `clk` where `tvalid && tready`.
- On each accepted input beat, every lane i (0..31) runs the same steps:
  - Potential update: p_i' = sat(p_i + (tdata[i] ? WEIGHT : 0)). Saturates at 2^POT_WIDTH−1; no wrap-around.
  - Fire test: fire_i = (p_i' >= THRESHOLD).
  - If fire_i, the potential is stored as 0; otherwise p_i' is stored.
  - The output beat for that input beat has `tdata[i]` = fire_i.
- Output `tkeep` equals the input beat's `tkeep`; output `tlast` equals the input beat's `tlast`.
- `tkeep` never masks processing: all 32 lanes are always updated.
- When the accepted beat has `tlast`=1, all potentials clear to 0 after that beat's fire computation. The next packet therefore starts from rest.
- Exactly one output beat is produced per input beat. Beats are never dropped, duplicated or reordered.

## Timing
- Output stage is a single register: `m_axis.tvalid/tdata/tkeep/tlast`.
- Latency: an output beat is valid on the cycle after its input is accepted.
- `s_axis.tready` = !m_tvalid_reg || `m_axis.tready` (combinational).
- Throughput is one beat per clock when the sink is always ready.
- `m_axis` obeys AXIS rules: while `tvalid`=1 and `tready`=0, `tdata/tkeep/tlast` are held stable.
- Simultaneous output handshake and input accept in the same cycle: the register loads the new beat and `tvalid` stays 1.
- Reset values while `arstn`=0:
  - `m_axis.tvalid`=0, `tdata`=0, `tkeep`=0, `tlast`=0.
  - All potentials 0.
  - `s_axis.tready`=1, since the output register is empty.
- Reset asserted mid-packet: the in-flight output beat is discarded and potentials clear. The next accepted beat is treated as the first of a new packet.

## Configuration
- `AXIS_PROCESSOR_LEAK_EN` defined:
  - On each accepted beat, any lane with no input spike first decrements its stored potential by 1 (floor 0).
  - The fire test is then applied unchanged.
- Not defined: potentials are held indefinitely between spikes (pure integrate-and-fire).

## Structure
- Package `axis_processor_pkg` holds:
  - `DATA_WIDTH`=32 and `KEEP_WIDTH`=4.
  - `typedef logic [DATA_WIDTH-1:0] spike_vec_t`.
  - The potential typedef parameterised by `POT_WIDTH`.
- Interface `axis` is shared codebase infrastructure and is not part of this block.
- One sub-module, `if_neuron`, holds a single lane's potential register, saturating add, fire compare, clear-on-last and optional leak. It is instantiated 32 times by a generate loop.
- The top level holds the output register and the handshake logic.

## Test plan
- Reset, then hold `m_axis.tready`=1 and send 4-beat packet `tdata` 1,0,0,0 with `tkeep`=F and `tlast` on beat 4.
  - Outputs: 0x00000001, 0, 0, 0 with `tlast` on the 4th beat only.
  - Each output arrives 1 cycle after its input is accepted; `s_tready` stays 1.
- With THRESHOLD=2, send 0x3, 0x1, 0x2, 0x0 (last).
  - Outputs: 0, 0x1, 0x2, 0.
- With THRESHOLD=2, send packet 0x1 (last), then packet 0x1 (last).
  - Both outputs are 0, confirming potentials clear at `tlast`.
- Backpressure: hold `m_axis.tready`=0 for 5 cycles mid-packet.
  - `s_tready` falls after one buffered beat and the output beat stays stable.
  - After release, all beats emerge in order and none is lost.
- Assert `arstn` low for 1 cycle mid-packet.
  - `m_tvalid` is 0 immediately and potentials are 0 on the next beat.
- `AXIS_PROCESSOR_LEAK_EN` with THRESHOLD=2: send 0x1, 0x0, 0x1.
  - All outputs 0; without the macro, output is 0x1 on beat 3.
